// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port synchronous-read memory; one transaction at a time.
// Write ack 2 cycles after req, read ack 2+MEM_LATENCY cycles; masters hold req until their ack.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int RR_EN       = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              gnt_id
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

   state_t            state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              gnt_q;
   logic              last_q;
   logic [1:0]        cnt_q;
   logic              any_req;
   logic              pick;

   assign any_req = m0_req | m1_req;

   // With both requesting, round-robin favours whoever was not served last.
   always_comb begin
      pick = 1'b0;
      if (m0_req && m1_req)
         pick = (RR_EN != 0) ? ~last_q : 1'b0;
      else if (m1_req)
         pick = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = we_q ? RESP : WAIT;
         WAIT:    if (cnt_q == 2'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 2'd0;
      end else begin
         if (state_q == IDLE && any_req) begin
            gnt_q   <= pick;
            we_q    <= pick ? m1_we    : m0_we;
            addr_q  <= pick ? m1_addr  : m0_addr;
            wdata_q <= pick ? m1_wdata : m0_wdata;
            rdata_q <= '0;
         end
         if (state_q == ACCESS && !we_q)
            cnt_q <= CNT_INIT;
         if (state_q == WAIT) begin
            if (cnt_q == 2'd0)
               rdata_q <= mem_rdata;
            else
               cnt_q <= cnt_q - 2'd1;
         end
         if (state_d == RESP && state_q != RESP)
            last_q <= gnt_q;
      end
   end

   // addr_q only reloads on the edge into ACCESS, so the memory bus holds between transactions.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state_q == ACCESS) && we_q;
   assign busy      = (state_q != IDLE);
   assign gnt_id    = gnt_q;
   assign m0_ack    = (state_q == RESP) && !gnt_q;
   assign m1_ack    = (state_q == RESP) &&  gnt_q;
   assign m0_rdata  = m0_ack ? rdata_q : '0;
   assign m1_rdata  = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (RR/latency 1, fixed priority, latency 3),
// each with its own word memory and read-latency pipeline.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic mem_init;

   logic        m0_req [3], m0_we [3], m1_req [3], m1_we [3];
   logic [31:0] m0_addr [3], m0_wdata [3], m1_addr [3], m1_wdata [3];
   logic        ack0 [3], ack1 [3], mwe [3], busy [3], gnt [3];
   logic [31:0] rd0 [3], rd1 [3], maddr [3], mwdata [3], mrdata [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int RR = (g == 1) ? 0 : 1;
      localparam int ML = (g == 2) ? 3 : 1;
      logic [31:0] mem [256];
      logic [31:0] pipe [4];

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML), .RR_EN(RR)) dut (
         .clk(clk), .reset(reset),
         .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
         .m0_ack(ack0[g]), .m0_rdata(rd0[g]),
         .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
         .m1_ack(ack1[g]), .m1_rdata(rd1[g]),
         .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_we(mwe[g]), .mem_rdata(mrdata[g]),
         .busy(busy[g]), .gnt_id(gnt[g])
      );

      always @(posedge clk) begin
         if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
         end else if (mwe[g]) begin
            mem[maddr[g][9:2]] <= mwdata[g];
         end
         pipe[0] <= mem[maddr[g][9:2]];
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign mrdata[g] = pipe[ML-1];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic logic get_ack(input int g, input int m);
      return (m == 1) ? ack1[g] : ack0[g];
   endfunction

   task automatic set_req(input int g, input int m, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      if (m == 1) begin
         m1_req[g] = r; m1_we[g] = w; m1_addr[g] = a; m1_wdata[g] = d;
      end else begin
         m0_req[g] = r; m0_we[g] = w; m0_addr[g] = a; m0_wdata[g] = d;
      end
   endtask

   // Single transaction: returns cycles from req to ack (-1 on timeout), read data,
   // number of mem_we cycles and the address/data seen on the write strobe.
   task automatic txn(input int g, input int m, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int cyc, output logic [31:0] rd,
                      output int wecnt, output logic [31:0] wa, output logic [31:0] wd);
      bit done = 0;
      set_req(g, m, 1'b1, w, a, d);
      cyc = 0; wecnt = 0; rd = '0; wa = '0; wd = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         cyc++;
         if (mwe[g]) begin wecnt++; wa = maddr[g]; wd = mwdata[g]; end
         if (get_ack(g, m)) begin
            rd = (m == 1) ? rd1[g] : rd0[g];
            done = 1;
         end
      end
      if (!done) cyc = -1;
      set_req(g, m, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      int cyc, wc, n, n0, n0_at_m1, both, extra, c0, c1;
      logic [31:0] rd, wa, wd, rdm0, rdm1;
      int got [4];
      int gnt_at [4];

      for (int g = 0; g < 3; g++) begin
         set_req(g, 0, 1'b0, 1'b0, '0, '0);
         set_req(g, 1, 1'b0, 1'b0, '0, '0);
      end
      reset = 1'b1;
      mem_init = 1'b1;
      tick();
      tick();
      mem_init = 1'b0;
      reset = 1'b0;

      // Reset state
      check("rst_busy",  32'(busy[0]), 32'd0);
      check("rst_acks",  32'({ack0[0], ack1[0]}), 32'd0);
      check("rst_mem_we", 32'(mwe[0]), 32'd0);
      check("rst_gnt",   32'(gnt[0]), 32'd0);
      check("rst_mem_addr", maddr[0], 32'd0);

      // 1: M0 read, latency 1
      txn(0, 0, 1'b0, 32'h10, 32'h0, cyc, rd, wc, wa, wd);
      check("t1_cycles", 32'(cyc), 32'd3);
      check("t1_rdata", rd, 32'hDEAD_BEEF);
      check("t1_we_cnt", 32'(wc), 32'd0);
      check("t1_gnt", 32'(gnt[0]), 32'd0);

      // 2: M1 write then M0 readback
      tick();
      txn(0, 1, 1'b1, 32'h200, 32'h1234_5678, cyc, rd, wc, wa, wd);
      check("t2_cycles", 32'(cyc), 32'd2);
      check("t2_we_cnt", 32'(wc), 32'd1);
      check("t2_we_addr", wa, 32'h200);
      check("t2_we_data", wd, 32'h1234_5678);
      check("t2_wr_rdata", rd, 32'd0);
      tick();
      txn(0, 0, 1'b0, 32'h200, 32'h0, cyc, rd, wc, wa, wd);
      check("t2_rb_cycles", 32'(cyc), 32'd3);
      check("t2_rb_rdata", rd, 32'h1234_5678);

      // 3: round-robin with both held high
      do_reset();
      set_req(0, 0, 1'b1, 1'b0, 32'h20, '0);
      set_req(0, 1, 1'b1, 1'b0, 32'h24, '0);
      n = 0; both = 0; rdm0 = '0; rdm1 = '0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         tick();
         if (ack0[0] && ack1[0]) both++;
         if (ack0[0] || ack1[0]) begin
            got[n] = ack1[0] ? 1 : 0;
            gnt_at[n] = int'(gnt[0]);
            if (ack0[0]) rdm0 = rd0[0]; else rdm1 = rd1[0];
            n++;
         end
      end
      set_req(0, 0, 1'b0, 1'b0, '0, '0);
      set_req(0, 1, 1'b0, 1'b0, '0, '0);
      check("t3_ack_count", 32'(n), 32'd4);
      check("t3_both_acks", 32'(both), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_order%0d", i), 32'(got[i]), 32'(i % 2));
         check($sformatf("t3_gnt%0d", i), 32'(gnt_at[i]), 32'(i % 2));
      end
      check("t3_m0_rdata", rdm0, 32'hA500_0008);
      check("t3_m1_rdata", rdm1, 32'hA500_0009);

      // 4: fixed priority, M1 served only after M0 drops
      do_reset();
      set_req(1, 0, 1'b1, 1'b0, 32'h20, '0);
      set_req(1, 1, 1'b1, 1'b0, 32'h24, '0);
      n0 = 0; n0_at_m1 = -1;
      for (int i = 0; i < 60 && n0_at_m1 < 0; i++) begin
         tick();
         if (ack1[1]) begin
            n0_at_m1 = n0;
            set_req(1, 1, 1'b0, 1'b0, '0, '0);
         end
         if (ack0[1]) begin
            n0++;
            if (n0 == 3) set_req(1, 0, 1'b0, 1'b0, '0, '0);
         end
      end
      set_req(1, 0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1, 1'b0, 1'b0, '0, '0);
      check("t4_m0_before_m1", 32'(n0_at_m1), 32'd3);

      // 5: latency 3, reset during WAIT
      do_reset();
      set_req(2, 0, 1'b1, 1'b0, 32'h10, '0);
      tick();
      tick();
      check("t5_busy_in_wait", 32'(busy[2]), 32'd1);
      reset = 1'b1;
      set_req(2, 0, 1'b0, 1'b0, '0, '0);
      tick();
      check("t5_busy_after_rst", 32'(busy[2]), 32'd0);
      check("t5_we_after_rst", 32'(mwe[2]), 32'd0);
      check("t5_gnt_after_rst", 32'(gnt[2]), 32'd0);
      check("t5_addr_after_rst", maddr[2], 32'd0);
      reset = 1'b0;
      extra = 0;
      if (ack0[2] || ack1[2]) extra++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ack0[2] || ack1[2]) extra++;
      end
      check("t5_no_ack", 32'(extra), 32'd0);
      txn(2, 0, 1'b0, 32'h10, 32'h0, cyc, rd, wc, wa, wd);
      check("t5_cycles", 32'(cyc), 32'd5);
      check("t5_rdata", rd, 32'hDEAD_BEEF);

      // 6: M0 drops req mid-transaction, M1 write follows
      tick();
      set_req(0, 0, 1'b1, 1'b0, 32'h30, '0);
      tick();
      tick();
      set_req(0, 0, 1'b0, 1'b0, '0, '0);
      set_req(0, 1, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
      c0 = 0; c1 = 0; rdm0 = '0; rdm1 = 32'hFFFF_FFFF;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack0[0]) begin c0++; rdm0 = rd0[0]; end
         if (ack1[0]) begin
            c1++;
            rdm1 = rd1[0];
            set_req(0, 1, 1'b0, 1'b0, '0, '0);
         end
      end
      set_req(0, 1, 1'b0, 1'b0, '0, '0);
      check("t6_m0_acks", 32'(c0), 32'd1);
      check("t6_m0_rdata", rdm0, 32'hA500_000C);
      check("t6_m1_acks", 32'(c1), 32'd1);
      check("t6_m1_rdata", rdm1, 32'd0);
      check("t6_idle", 32'(busy[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
